lifo_stack: RTL

Parametrised LIFO stack, successor to the fixed 2-bit/50-entry game-move stack. Adds configurable data width and depth, selectable edge-detect or strobe request mode, and full/empty flags with a live count. Adds sticky overflow/underflow errors, a combinational top-of-stack peek, and defined simultaneous push+pop (replace) behaviour. Sits between the input/control FSM (undo/redo history) and display logic.

---
 rtl/lifo_pkg.sv | 16 +
 rtl/lifo_stack_if.sv | 34 +++
 rtl/lifo_stack_edge_pulse.sv | 21 ++
 rtl/lifo_stack.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
package lifo_pkg;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } lifo_op_t;

  // Bits needed to hold any value 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Request/response bundle between a controller (master) and the LIFO stack (slave).
interface lifo_stack_if
  import lifo_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 50
);
  localparam int CW = count_width(DEPTH);

  logic             en;
  logic             clear;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic [WIDTH-1:0] top_data;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output en, clear, push, push_data, pop,
    input  pop_data, pop_valid, top_data, count, empty, full, overflow, underflow
  );

  modport slave (
    input  en, clear, push, push_data, pop,
    output pop_data, pop_valid, top_data, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/lifo_stack_edge_pulse.sv
// Rising-edge detector; with BYPASS set the level passes straight through as a strobe.
module edge_pulse #(
  parameter bit BYPASS = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level_i;
  end

  assign pulse_o = BYPASS ? level_i : (level_i & ~level_q);

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with edge/strobe requests, replace-on-push+pop and sticky errors.
module lifo_stack
  import lifo_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int DEPTH       = 50,
  parameter bit EDGE_DETECT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  lifo_stack_if.slave  bus
);

  localparam int CW = count_width(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic             pop_valid_q, pop_valid_d;

  logic             push_req, pop_req;
  lifo_op_t         op;
  logic             is_empty, is_full;
  logic [AW-1:0]    top_idx, wr_idx;
  logic             mem_we;
  logic [WIDTH-1:0] top_word;

  edge_pulse #(.BYPASS(!EDGE_DETECT)) u_push_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (bus.push),
    .pulse_o (push_req)
  );

  edge_pulse #(.BYPASS(!EDGE_DETECT)) u_pop_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (bus.pop),
    .pulse_o (pop_req)
  );

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign top_idx  = AW'(count_q - CW'(1));
  assign top_word = mem[top_idx];

  always_comb begin
    op = OP_NONE;
    if (bus.en) begin
      case ({push_req, pop_req})
        2'b10:   op = OP_PUSH;
        2'b01:   op = OP_POP;
        2'b11:   op = OP_REPLACE;
        default: op = OP_NONE;
      endcase
    end
  end

  // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    pop_data_d  = '0;
    pop_valid_d = 1'b0;
    mem_we      = 1'b0;
    wr_idx      = AW'(count_q);

    if (bus.clear) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
        OP_POP: begin
          if (is_empty) begin
            underflow_d = 1'b1;
          end else begin
            pop_data_d  = top_word;
            pop_valid_d = 1'b1;
            count_d     = count_q - CW'(1);
          end
        end
        OP_REPLACE: begin
          // Empty stack: the pop half fails but the push half still lands at slot 0.
          mem_we = 1'b1;
          if (is_empty) begin
            underflow_d = 1'b1;
            count_d     = CW'(1);
          end else begin
            wr_idx      = top_idx;
            pop_data_d  = top_word;
            pop_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
    end
  end

  // NOTE: the array is deliberately not reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= bus.push_data;
  end

  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.pop_data  = pop_data_q;
  assign bus.pop_valid = pop_valid_q;
  assign bus.top_data  = is_empty ? '0 : top_word;

endmodule
